// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART transmit feeder.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        REQ  = 2'd2,
        REL  = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with flush, occupancy count and registered-level Full/Empty flags.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic [UART_BYTE_W-1:0] WrData,
    input  logic                   WrEn,
    input  logic                   RdEn,
    input  logic                   Flush,
    output logic [UART_BYTE_W-1:0] RdData,
    output logic                   Full,
    output logic                   Empty,
    output logic [DEPTH_LOG2:0]    Level
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [UART_BYTE_W-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0]  wptr;
    logic [DEPTH_LOG2-1:0]  rptr;
    logic                   wr_ok;
    logic                   rd_ok;

    assign Full   = (Level == FULL_LEVEL);
    assign Empty  = (Level == '0);
    // Flush outranks a same-cycle write; a same-cycle pop still sees the head byte.
    assign wr_ok  = WrEn & ~Full & ~Flush;
    assign rd_ok  = RdEn & ~Empty;
    assign RdData = mem[rptr];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            wptr  <= '0;
            rptr  <= '0;
            Level <= '0;
        end else if (Flush) begin
            wptr  <= '0;
            rptr  <= '0;
            Level <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   Level <= Level + 1'b1;
                2'b01:   Level <= Level - 1'b1;
                default: Level <= Level;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_ok) mem[wptr] <= WrData;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to the UART sender over its Send/Busy level handshake.
// Optional sticky drop flag: define UART_TX_FEEDER_OVERFLOW_EN to add Overflow/OvfClear.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                   Clk,
    input  logic                   nReset,
    input  logic [UART_BYTE_W-1:0] WrData,
    input  logic                   WrEn,
    input  logic                   Flush,
    output logic                   Full,
    output logic                   Empty,
    output logic [DEPTH_LOG2:0]    Level,
    output logic [UART_BYTE_W-1:0] TxData,
    output logic                   TxSend,
    input  logic                   TxBusy,
    output logic                   Idle
`ifdef UART_TX_FEEDER_OVERFLOW_EN
    ,
    output logic                   Overflow,
    input  logic                   OvfClear
`endif
);

    feeder_state_t          state;
    feeder_state_t          next_state;
    logic                   pop;
    logic [UART_BYTE_W-1:0] head;

    uart_sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .Clk    (Clk),
        .nReset (nReset),
        .WrData (WrData),
        .WrEn   (WrEn),
        .RdEn   (pop),
        .Flush  (Flush),
        .RdData (head),
        .Full   (Full),
        .Empty  (Empty),
        .Level  (Level)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state  <= IDLE;
            TxData <= '0;
        end else begin
            state <= next_state;
            if (pop) TxData <= head;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        TxSend     = 1'b0;
        case (state)
            // A same-cycle flush would leave LOAD with nothing to pop, so hold off.
            IDLE: if (!Empty && !TxBusy && !Flush) next_state = LOAD;
            LOAD: begin
                pop        = 1'b1;
                next_state = REQ;
            end
            REQ: begin
                TxSend = 1'b1;
                if (TxBusy) next_state = REL;
            end
            REL: if (!TxBusy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign Idle = Empty && (state == IDLE) && !TxBusy;

`ifdef UART_TX_FEEDER_OVERFLOW_EN
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            Overflow <= 1'b0;
        end else if (OvfClear) begin
            Overflow <= 1'b0;
        end else if (WrEn && (Full || Flush)) begin
            Overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: behavioural sender model plus in-order byte scoreboard.
module tb_uart_tx_feeder;

    localparam int DL    = 4;
    localparam int DEPTH = 16;

    logic          Clk    = 1'b0;
    logic          nReset = 1'b0;
    logic [7:0]    WrData = '0;
    logic          WrEn   = 1'b0;
    logic          Flush  = 1'b0;
    logic          Full;
    logic          Empty;
    logic [DL:0]   Level;
    logic [7:0]    TxData;
    logic          TxSend;
    logic          TxBusy;
    logic          Idle;
`ifdef UART_TX_FEEDER_OVERFLOW_EN
    logic          Overflow;
    logic          OvfClear = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Sender model: registers Send, raises Busy for a frame, releases only after Send is low.
    logic       hold_busy    = 1'b0;
    logic       stall_accept = 1'b0;
    int         frame_len    = 4;
    logic       sb_send_q    = 1'b0;
    logic       sb_busy      = 1'b0;
    int         sb_cnt       = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    assign TxBusy = sb_busy | hold_busy;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        sb_send_q <= TxSend;
        if (!sb_busy) begin
            if (sb_send_q && !stall_accept) begin
                sb_busy <= 1'b1;
                sb_cnt  <= frame_len;
                rx_q.push_back(TxData);
            end
        end else if (sb_cnt > 0) begin
            sb_cnt <= sb_cnt - 1;
        end else if (!sb_send_q) begin
            sb_busy <= 1'b0;
        end
    end

    uart_tx_feeder #(
        .DEPTH_LOG2(DL)
    ) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .WrData   (WrData),
        .WrEn     (WrEn),
        .Flush    (Flush),
        .Full     (Full),
        .Empty    (Empty),
        .Level    (Level),
        .TxData   (TxData),
        .TxSend   (TxSend),
        .TxBusy   (TxBusy),
        .Idle     (Idle)
`ifdef UART_TX_FEEDER_OVERFLOW_EN
        ,
        .Overflow (Overflow),
        .OvfClear (OvfClear)
`endif
    );

    task automatic tick();
        @(negedge Clk);
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return TxSend;
            1:       return TxBusy;
            default: return Idle;
        endcase
    endfunction

    task automatic wait_sig(input int w, input logic v, input int budget, input string name);
        int n = 0;
        while (sel(w) !== v && n < budget) begin
            tick();
            n++;
        end
        if (sel(w) !== v) begin
            checks++;
            errors++;
            $display("FAIL %s: timed out after %0d cycles, got %b want %b", name, budget, sel(w), v);
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        rx_q.delete();
    endtask

    // Outstanding bytes bound the FIFO occupancy, so a write below 16 outstanding is never dropped.
    task automatic write_byte(input logic [7:0] b);
        int n = 0;
        while ((exp_q.size() - rx_q.size()) >= DEPTH && n < 5000) begin
            tick();
            n++;
        end
        if ((exp_q.size() - rx_q.size()) >= DEPTH) begin
            checks++;
            errors++;
            $display("FAIL write_room: no room after %0d cycles", n);
        end
        WrData = b;
        WrEn   = 1'b1;
        tick();
        WrEn   = 1'b0;
        exp_q.push_back(b);
    endtask

    task automatic drain_and_compare(input string name);
        int n = 0;
        while (!(rx_q.size() >= exp_q.size() && Idle === 1'b1) && n < 20000) begin
            tick();
            n++;
        end
        checks++;
        if (rx_q.size() != exp_q.size() || Idle !== 1'b1) begin
            errors++;
            $display("FAIL %s_count: received %0d bytes idle=%b, want %0d bytes idle=1",
                     name, rx_q.size(), Idle, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h want %h", name, i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (Level !== '0)     begin errors++; $display("FAIL rst_level: got %0d want 0", Level); end
        if (Empty !== 1'b1)   begin errors++; $display("FAIL rst_empty: got %b want 1", Empty); end
        if (Full !== 1'b0)    begin errors++; $display("FAIL rst_full: got %b want 0", Full); end
        if (TxData !== 8'h00) begin errors++; $display("FAIL rst_txdata: got %h want 00", TxData); end
        if (TxSend !== 1'b0)  begin errors++; $display("FAIL rst_txsend: got %b want 0", TxSend); end
        if (Idle !== 1'b1)    begin errors++; $display("FAIL rst_idle: got %b want 1", Idle); end
        nReset = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_byte();
        clear_queues();
        frame_len = 6;
        write_byte(8'h41);
        wait_sig(0, 1'b1, 20, "single_send_rise");
        checks++;
        if (TxData !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", TxData); end
        wait_sig(1, 1'b1, 20, "single_busy_rise");
        tick();
        checks++;
        if (TxSend !== 1'b0) begin errors++; $display("FAIL single_send_drop: got %b want 0", TxSend); end
        wait_sig(1, 1'b0, 50, "single_busy_fall");
        tick();
        checks++;
        if (Idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b want 1", Idle); end
        drain_and_compare("single");
    endtask

    task automatic test_burst_full();
        clear_queues();
        hold_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        checks += 2;
        if (Full !== 1'b1) begin errors++; $display("FAIL burst_full: got %b want 1", Full); end
        if (Level !== (DL+1)'(DEPTH)) begin errors++; $display("FAIL burst_level: got %0d want 16", Level); end
        WrData = 8'hFF;
        WrEn   = 1'b1;
        tick();
        WrEn   = 1'b0;
        checks++;
        if (Level !== (DL+1)'(DEPTH)) begin errors++; $display("FAIL burst_drop_level: got %0d want 16", Level); end
`ifdef UART_TX_FEEDER_OVERFLOW_EN
        checks++;
        if (Overflow !== 1'b1) begin errors++; $display("FAIL burst_ovf_set: got %b want 1", Overflow); end
        WrEn     = 1'b1;
        OvfClear = 1'b1;
        tick();
        WrEn     = 1'b0;
        OvfClear = 1'b0;
        checks++;
        if (Overflow !== 1'b0) begin errors++; $display("FAIL burst_ovf_clear: got %b want 0", Overflow); end
`endif
        hold_busy = 1'b0;
        frame_len = 3;
        drain_and_compare("burst");
    endtask

    task automatic test_same_cycle_wrap();
        clear_queues();
        hold_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'($urandom));
        checks++;
        if (Level !== (DL+1)'(5)) begin errors++; $display("FAIL wrap_level5: got %0d want 5", Level); end
        hold_busy = 1'b0;
        tick();
        WrData = 8'($urandom);
        WrEn   = 1'b1;
        exp_q.push_back(WrData);
        tick();
        WrEn   = 1'b0;
        checks++;
        if (Level !== (DL+1)'(5)) begin errors++; $display("FAIL wrap_same_cycle: got %0d want 5", Level); end
        for (int i = 0; i < 14; i++) write_byte(8'($urandom));
        drain_and_compare("wrap");
    endtask

    task automatic test_flush_in_req();
        clear_queues();
        hold_busy = 1'b1;
        write_byte(8'hA5);
        for (int i = 0; i < 3; i++) write_byte(8'($urandom));
        stall_accept = 1'b1;
        hold_busy    = 1'b0;
        wait_sig(0, 1'b1, 20, "flush_send_rise");
        repeat (3) tick();
        checks += 2;
        if (TxData !== 8'hA5) begin errors++; $display("FAIL flush_pre_data: got %h want a5", TxData); end
        if (Level !== (DL+1)'(3)) begin errors++; $display("FAIL flush_pre_level: got %0d want 3", Level); end
        Flush  = 1'b1;
        WrEn   = 1'b1;
        WrData = 8'h77;
        tick();
        Flush  = 1'b0;
        WrEn   = 1'b0;
        checks += 3;
        if (Level !== '0) begin errors++; $display("FAIL flush_level: got %0d want 0", Level); end
        if (TxSend !== 1'b1) begin errors++; $display("FAIL flush_send_kept: got %b want 1", TxSend); end
        if (TxData !== 8'hA5) begin errors++; $display("FAIL flush_data_kept: got %h want a5", TxData); end
`ifdef UART_TX_FEEDER_OVERFLOW_EN
        checks++;
        if (Overflow !== 1'b1) begin errors++; $display("FAIL flush_ovf: got %b want 1", Overflow); end
        OvfClear = 1'b1;
        tick();
        OvfClear = 1'b0;
`endif
        exp_q.delete();
        exp_q.push_back(8'hA5);
        stall_accept = 1'b0;
        drain_and_compare("flush");
        begin
            int extra = 0;
            repeat (30) begin
                tick();
                if (TxSend !== 1'b0) extra++;
            end
            checks++;
            if (extra != 0) begin errors++; $display("FAIL flush_no_more_send: TxSend high %0d cycles want 0", extra); end
        end
    endtask

    task automatic test_random_stream();
        clear_queues();
        for (int i = 0; i < 50; i++) begin
            frame_len = $urandom_range(2, 10);
            repeat ($urandom_range(0, 4)) tick();
            write_byte(8'($urandom));
        end
        drain_and_compare("random");
    endtask

    task automatic test_long_stall();
        logic [7:0] b;
        int bad = 0;
        clear_queues();
        b = 8'($urandom);
        stall_accept = 1'b1;
        write_byte(b);
        wait_sig(0, 1'b1, 20, "stall_send_rise");
        repeat (1000) begin
            tick();
            if (TxSend !== 1'b1 || TxData !== b) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d cycles lost Send/data want 0 (data %h)", bad, b); end
        stall_accept = 1'b0;
        drain_and_compare("stall");
    endtask

    task automatic test_async_reset();
        int bad = 0;
        clear_queues();
        stall_accept = 1'b1;
        write_byte(8'($urandom));
        write_byte(8'($urandom));
        wait_sig(0, 1'b1, 20, "areset_send_rise");
        #2;
        nReset    = 1'b0;
        hold_busy = 1'b1;
        #1;
        checks += 3;
        if (TxSend !== 1'b0) begin errors++; $display("FAIL areset_send: got %b want 0", TxSend); end
        if (Level !== '0) begin errors++; $display("FAIL areset_level: got %0d want 0", Level); end
        if (Empty !== 1'b1) begin errors++; $display("FAIL areset_empty: got %b want 1", Empty); end
        repeat (2) tick();
        nReset = 1'b1;
        tick();
        stall_accept = 1'b0;
        clear_queues();
        write_byte(8'hC3);
        repeat (10) begin
            tick();
            if (TxSend !== 1'b0 || Level !== (DL+1)'(1) || Idle !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL areset_wait_busy: %0d cycles left IDLE early want 0", bad); end
        hold_busy = 1'b0;
        drain_and_compare("areset");
    endtask

    initial begin
        tick();
        test_reset();
        test_single_byte();
        test_burst_full();
        test_same_cycle_wrap();
        test_flush_in_req();
        test_random_stream();
        test_long_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
